// File: rtl/button_debounce_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and the
// state-to-output decode used by the top level.
package button_debounce_pkg;

    // DB_* are settled levels, ARM_* are qualification windows towards the
    // opposite level. The output follows the settled level until a window
    // completes.
    typedef enum logic [1:0] {
        DB_LO  = 2'd0,
        ARM_HI = 2'd1,
        DB_HI  = 2'd2,
        ARM_LO = 2'd3
    } db_state_e;

    // Pressed level is reported while settled high or while qualifying a release.
    function automatic logic state_out(db_state_e s);
        return (s == DB_HI) || (s == ARM_LO);
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button-side signal bundle: sample enable and raw pin towards the debouncer,
// debounced pressed level back out.
interface button_debounce_if;
    logic tick;
    logic in;
    logic out;

    modport master (output tick, output in, input out);
    modport slave  (input tick, input in, output out);
endinterface

// File: rtl/button_debounce_sync2.sv
// Two-flop synchronizer for an asynchronous pin. Resets to RST_VAL so the
// pin reads as idle immediately after reset. Reusable for other raw inputs.
module button_debounce_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    // Metastability chain, always clocked regardless of any sample enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes a raw bouncy pin, then changes the
// registered pressed level only after STABLE_CYCLES consecutive agreeing
// samples (samples are clock edges with tick=1).
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    button_debounce_if.slave   bus
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic             PIN_IDLE = ACTIVE_LOW;

    logic             s2;
    logic             lvl;
    db_state_e        state_reg;
    db_state_e        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    button_debounce_sync2 #(
        .RST_VAL (PIN_IDLE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.in),
        .q     (s2)
    );

    // Normalize to active-high "pressed".
    assign lvl = s2 ^ PIN_IDLE;

    // Next-state: advance only on sampled cycles; any disagreement during a
    // window falls back to the settled level with the count cleared.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (bus.tick) begin
            case (state_reg)
                DB_LO: begin
                    if (lvl) begin
                        if (STABLE_CYCLES == 1) begin
                            state_next = DB_HI;
                        end else begin
                            state_next = ARM_HI;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                ARM_HI: begin
                    if (!lvl) begin
                        state_next = DB_LO;
                        cnt_next   = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = DB_HI;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                DB_HI: begin
                    if (!lvl) begin
                        if (STABLE_CYCLES == 1) begin
                            state_next = DB_LO;
                        end else begin
                            state_next = ARM_LO;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                ARM_LO: begin
                    if (lvl) begin
                        state_next = DB_HI;
                        cnt_next   = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = DB_LO;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = DB_LO;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State and window counter; reset restarts qualification from released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= DB_LO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Output is a pure decode of the state register, so it is glitch-free.
    assign bus.out = state_out(state_reg);

endmodule
